// File: rtl/rc4_pkg.sv
// Types and sizes shared by the RC4 S-memory engines (initializer, reader, swap engine).
package rc4_pkg;

    localparam int unsigned DEPTH_S  = 256;
    localparam int unsigned ADDR_W_S = 8;
    localparam int unsigned DATA_W_S = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } sweep_state_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid+tag delay line matching a synchronous RAM's read latency.
module rd_tag_pipe #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned TAG_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    logic             valid_q [LATENCY];
    logic             valid_d [LATENCY];
    logic [TAG_W-1:0] tag_q   [LATENCY];
    logic [TAG_W-1:0] tag_d   [LATENCY];

    always_comb begin
        valid_d[0] = in_valid;
        tag_d[0]   = in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= valid_d[i];
                tag_q[i]   <= tag_d[i];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: rtl/s_mem_reader.sv
// Sweeps the S memory once per start and checks every word against S[i] = i.
module s_mem_reader
    import rc4_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_S,
    parameter int unsigned DATA_W     = DATA_W_S,
    parameter int unsigned DEPTH      = DEPTH_S,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] address,
    output logic              wren,
    output logic              busy,
    output logic              complete,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    // Counter is one bit wider so DEPTH = 2**ADDR_W still has a reachable terminal value.
    localparam logic [ADDR_W:0] LastAddr  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] MaxErr    = (ADDR_W+1)'(DEPTH);
    localparam logic [1:0]      LastDrain = 2'(RD_LATENCY - 1);

    sweep_state_e      state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [1:0]        drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              complete_q, complete_d;
    logic              pass_q, pass_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;

    logic              tag_valid;
    logic [ADDR_W-1:0] tag_addr;
    logic [DATA_W-1:0] exp_word;

    rd_tag_pipe #(
        .LATENCY (RD_LATENCY),
        .TAG_W   (ADDR_W)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (state_q == StRead),
        .in_tag    (addr_q[ADDR_W-1:0]),
        .out_valid (tag_valid),
        .out_tag   (tag_addr)
    );

    assign exp_word = DATA_W'(tag_addr);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        drain_d    = drain_q;
        busy_d     = busy_q;
        complete_d = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        first_d    = first_q;

        if (tag_valid && (q != exp_word)) begin
            if (err_q == '0) begin
                first_d = tag_addr;
            end
            if (err_q != MaxErr) begin
                err_d = err_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                end
            end
            StRead: begin
                if (addr_q == LastAddr) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: begin
                // The last compare lands on this edge, so judge pass on err_d.
                if (drain_q == LastDrain) begin
                    state_d    = StDone;
                    busy_d     = 1'b0;
                    complete_d = 1'b1;
                    addr_d     = '0;
                    pass_d     = (err_d == '0);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            first_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            first_q    <= first_d;
        end
    end

    assign address        = addr_q[ADDR_W-1:0];
    assign wren           = 1'b0;
    assign busy           = busy_q;
    assign complete       = complete_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule
